// File: rtl/reaction_round_ctrl.sv
// Multi-player reaction round controller: LFSR fore-period, millisecond timing,
// first-press arbitration, false-start/timeout detection and session best time.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | after reset, waiting for the first start edge
//   S_ARMED   | fore-period running; any press is a false start
//   S_GO      | lamp on, counting ticks until a press or timeout
//   S_RESULT  | valid press captured; winner and ms_count held
//   S_FALSE   | early press captured; fs_player held
//   S_TIMEOUT | nobody pressed; ms_count held at MAX_COUNT
module reaction_round_ctrl #(
   parameter int          NUM_PLAYERS = 2,
   parameter int          CLK_HZ      = 100000000,
   parameter int          TICK_HZ     = 1000,
   parameter int          MIN_DELAY   = 1000,
   parameter int          RAND_BITS   = 11,
   parameter int          MAX_COUNT   = 9999,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_PLAYERS-1:0] btn,
   output logic                   go,
   output logic                   busy,
   output logic [13:0]            ms_count,
   output logic [2:0]             winner,
   output logic                   winner_valid,
   output logic                   false_start,
   output logic [2:0]             fs_player,
   output logic                   timeout,
   output logic [13:0]            best_time,
   output logic                   best_valid
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int TCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DLY_W    = $clog2(MIN_DELAY + (2 ** RAND_BITS) + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_GO,
      S_RESULT,
      S_FALSE,
      S_TIMEOUT
   } state_t;

   state_t                   r_state;
   logic [15:0]              r_lfsr;
   logic                     r_start_prev;
   logic [NUM_PLAYERS-1:0]   r_btn_prev;
   logic [TCNT_W-1:0]        r_tick_cnt;
   logic [DLY_W-1:0]         r_delay;
   logic [13:0]              r_ms;
   logic [2:0]               r_winner;
   logic                     r_winner_valid;
   logic                     r_false;
   logic [2:0]               r_fs_player;
   logic                     r_timeout;
   logic                     r_go;
   logic                     r_busy;
   logic [13:0]              r_best_time;
   logic                     r_best_valid;

   logic                     w_start_edge;
   logic [NUM_PLAYERS-1:0]   w_btn_edge;
   logic                     w_any_btn;
   logic                     w_tick;
   logic [15:0]              w_lfsr_next;
   logic [DLY_W-1:0]         w_delay_load;
   logic                     w_enter_armed;
   logic [2:0]               w_first_idx;

   assign w_start_edge  = start & ~r_start_prev;
   assign w_btn_edge    = btn & ~r_btn_prev;
   assign w_any_btn     = |w_btn_edge;
   assign w_tick        = (r_tick_cnt == TCNT_W'(TICK_DIV - 1));
   assign w_lfsr_next   = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
   assign w_delay_load  = DLY_W'(MIN_DELAY) + DLY_W'(r_lfsr[RAND_BITS-1:0]);
   // A new round can start from idle or from any of the three finished states.
   assign w_enter_armed = w_start_edge &&
                          (r_state inside {S_IDLE, S_RESULT, S_FALSE, S_TIMEOUT});

   // Scan high to low so the lowest simultaneous presser wins.
   always_comb begin
      w_first_idx = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (w_btn_edge[i]) w_first_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_lfsr         <= LFSR_SEED;
         r_start_prev   <= 1'b1;
         r_btn_prev     <= '1;
         r_tick_cnt     <= '0;
         r_delay        <= '0;
         r_ms           <= '0;
         r_winner       <= '0;
         r_winner_valid <= 1'b0;
         r_false        <= 1'b0;
         r_fs_player    <= '0;
         r_timeout      <= 1'b0;
         r_go           <= 1'b0;
         r_busy         <= 1'b0;
         r_best_time    <= 14'h3FFF;
         r_best_valid   <= 1'b0;
      end else begin
         r_lfsr       <= w_lfsr_next;
         r_start_prev <= start;
         r_btn_prev   <= btn;
         r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;

         if (w_enter_armed) begin
            r_state        <= S_ARMED;
            r_delay        <= w_delay_load;
            r_ms           <= '0;
            r_tick_cnt     <= '0;
            r_busy         <= 1'b1;
            r_go           <= 1'b0;
            r_winner_valid <= 1'b0;
            r_false        <= 1'b0;
            r_timeout      <= 1'b0;
         end else begin
            case (r_state)
               S_ARMED: begin
                  if (w_any_btn) begin
                     r_state     <= S_FALSE;
                     r_fs_player <= w_first_idx;
                     r_false     <= 1'b1;
                     r_busy      <= 1'b0;
                  end else if (w_tick) begin
                     if (r_delay < DLY_W'(2)) begin
                        r_state    <= S_GO;
                        r_go       <= 1'b1;
                        r_ms       <= '0;
                        r_tick_cnt <= '0;
                     end else begin
                        r_delay <= r_delay - 1'b1;
                     end
                  end
               end
               S_GO: begin
                  // A press freezes r_ms as-is; a coincident tick is dropped.
                  if (w_any_btn) begin
                     r_state        <= S_RESULT;
                     r_winner       <= w_first_idx;
                     r_winner_valid <= 1'b1;
                     r_go           <= 1'b0;
                     r_busy         <= 1'b0;
                     if (!r_best_valid || (r_ms < r_best_time)) begin
                        r_best_time  <= r_ms;
                        r_best_valid <= 1'b1;
                     end
                  end else if (w_tick) begin
                     if (r_ms >= 14'(MAX_COUNT - 1)) begin
                        r_state   <= S_TIMEOUT;
                        r_ms      <= 14'(MAX_COUNT);
                        r_timeout <= 1'b1;
                        r_go      <= 1'b0;
                        r_busy    <= 1'b0;
                     end else begin
                        r_ms <= r_ms + 14'd1;
                     end
                  end
               end
               S_IDLE, S_RESULT, S_FALSE, S_TIMEOUT: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign go           = r_go;
   assign busy         = r_busy;
   assign ms_count     = r_ms;
   assign winner       = r_winner;
   assign winner_valid = r_winner_valid;
   assign false_start  = r_false;
   assign fs_player    = r_fs_player;
   assign timeout      = r_timeout;
   assign best_time    = r_best_time;
   assign best_valid   = r_best_valid;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: tick every 10 cycles, fore-period
// 5..8 ticks, timeout at 50, four players.
module tb_reaction_round_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  btn = 4'b0000;
   logic        go, busy, winner_valid, false_start, timeout, best_valid;
   logic [13:0] ms_count, best_time;
   logic [2:0]  winner, fs_player;

   int          checks = 0;
   int          errors = 0;
   int          d;
   int          n;
   logic [15:0] m_lfsr;
   logic        flag;

   reaction_round_ctrl #(
      .NUM_PLAYERS(4), .CLK_HZ(1000), .TICK_HZ(100), .MIN_DELAY(5),
      .RAND_BITS(2), .MAX_COUNT(50), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .btn(btn),
      .go(go), .busy(busy), .ms_count(ms_count), .winner(winner),
      .winner_valid(winner_valid), .false_start(false_start),
      .fs_player(fs_player), .timeout(timeout),
      .best_time(best_time), .best_valid(best_valid)
   );

   always #5 clk = ~clk;

   // Reference LFSR: 16-bit Galois, taps 0xB400, stepping every cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Called at a falling edge; returns the fore-period the DUT will load.
   task automatic start_round(output int dly);
      dly = 5 + int'(m_lfsr[1:0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("arm_busy", 32'(busy), 1);
      check("arm_ms_clear", 32'(ms_count), 0);
      check("arm_go_low", 32'(go), 0);
   endtask

   // Counts falling edges since the start edge until go rises; busy must stay high.
   task automatic wait_go(input string tag, input int dly);
      int  cyc;
      logic busy_ok;
      cyc = 1;
      busy_ok = 1'b1;
      while (!go && cyc < 10 * dly + 20) begin
         @(negedge clk);
         cyc++;
         if (!busy) busy_ok = 1'b0;
      end
      check_range(tag, go ? cyc : -1, 10 * dly, 10 * dly + 2);
      check("busy_through_armed", 32'(busy_ok), 1);
   endtask

   // From the cycle go is first seen, waits for ms_count==target then presses.
   task automatic press_at(input string tag, input int target, input logic [3:0] mask);
      int cyc;
      cyc = 0;
      while (ms_count != 14'(target) && cyc < 10 * target + 20) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(cyc), 32'(10 * target));
      btn = mask;
      @(negedge clk);
      btn = 4'b0000;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_go", 32'(go), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ms", 32'(ms_count), 0);
      check("rst_wv", 32'(winner_valid), 0);
      check("rst_fs", 32'(false_start), 0);
      check("rst_to", 32'(timeout), 0);
      check("rst_best_time", 32'(best_time), 32'h3FFF);
      check("rst_best_valid", 32'(best_valid), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // Round 1: start when the LFSR low bits are 2 -> fore-period 7 ticks
      n = 0;
      while (m_lfsr[1:0] != 2'd2 && n < 64) begin
         @(negedge clk);
         n++;
      end
      start_round(d);
      check("r1_delay", 32'(d), 7);
      wait_go("r1_go_latency", d);
      press_at("r1_tick_period", 13, 4'b0100);
      check("r1_wv", 32'(winner_valid), 1);
      check("r1_winner", 32'(winner), 2);
      check("r1_ms", 32'(ms_count), 13);
      check("r1_go_off", 32'(go), 0);
      check("r1_busy_off", 32'(busy), 0);
      check("r1_best", 32'(best_time), 13);
      check("r1_best_valid", 32'(best_valid), 1);
      repeat (25) @(negedge clk);
      check("r1_ms_hold", 32'(ms_count), 13);
      check("r1_wv_hold", 32'(winner_valid), 1);

      // Round 2: simultaneous press of players 3 and 1, slower than best
      start_round(d);
      check("r2_wv_clear", 32'(winner_valid), 0);
      wait_go("r2_go_latency", d);
      press_at("r2_wait", 20, 4'b1010);
      check("r2_winner", 32'(winner), 1);
      check("r2_ms", 32'(ms_count), 20);
      check("r2_best_kept", 32'(best_time), 13);

      // Round 3: faster press updates best
      start_round(d);
      wait_go("r3_go_latency", d);
      press_at("r3_wait", 9, 4'b1000);
      check("r3_winner", 32'(winner), 3);
      check("r3_ms", 32'(ms_count), 9);
      check("r3_best", 32'(best_time), 9);

      // Round 4: early press during the fore-period
      start_round(d);
      repeat (20) @(negedge clk);
      btn = 4'b0001;
      @(negedge clk);
      btn = 4'b0000;
      check("r4_false", 32'(false_start), 1);
      check("r4_fs_player", 32'(fs_player), 0);
      check("r4_busy", 32'(busy), 0);
      check("r4_wv", 32'(winner_valid), 0);
      flag = 1'b0;
      repeat (10 * d + 20) begin
         @(negedge clk);
         if (go) flag = 1'b1;
      end
      check("r4_go_never", 32'(flag), 0);
      check("r4_false_hold", 32'(false_start), 1);

      // Round 5: press lands on the same edge as the final fore-period tick
      start_round(d);
      check("r5_false_clear", 32'(false_start), 0);
      repeat (10 * d - 1) @(negedge clk);
      check("r5_go_before", 32'(go), 0);
      btn = 4'b0100;
      @(negedge clk);
      btn = 4'b0000;
      check("r5_false", 32'(false_start), 1);
      check("r5_fs_player", 32'(fs_player), 2);
      check("r5_go_low", 32'(go), 0);

      // Round 6: nobody presses -> timeout at 50
      start_round(d);
      wait_go("r6_go_latency", d);
      n = 0;
      while (!timeout && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("r6_timeout_cycles", 32'(n), 500);
      check("r6_ms", 32'(ms_count), 50);
      check("r6_go_off", 32'(go), 0);
      check("r6_wv", 32'(winner_valid), 0);
      check("r6_best_kept", 32'(best_time), 9);
      repeat (20) @(negedge clk);
      check("r6_ms_hold", 32'(ms_count), 50);
      start_round(d);
      check("r6_timeout_clear", 32'(timeout), 0);

      // Round 7: async reset mid-GO with inputs held across release
      wait_go("r7_go_latency", d);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      btn = 4'b0010;
      start = 1'b1;
      #1;
      check("ar_go", 32'(go), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_ms", 32'(ms_count), 0);
      check("ar_best_time", 32'(best_time), 32'h3FFF);
      check("ar_best_valid", 32'(best_valid), 0);
      check("ar_wv", 32'(winner_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("held_start_no_edge", 32'(busy), 0);
      start = 1'b0;
      @(negedge clk);
      start_round(d);
      wait_go("r7b_go_latency", d);
      check("held_btn_no_false", 32'(false_start), 0);
      btn = 4'b0000;
      press_at("r7b_wait", 4, 4'b0010);
      check("r7b_winner", 32'(winner), 1);
      check("r7b_best", 32'(best_time), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
